div_seq_ctrl: RTL and testbench

- Multi-cycle controller for MIPS DIV/DIVU that time-shares a single fa32 add/sub instance. It handles operand negation, 32 restoring-division steps, and result sign fix-up.
- Sits in the EX stage beside the multiplier and writes HI (remainder) and LO (quotient).
- Fixed latency, so pipeline stall logic needs only busy_o and done_o.

---
 rtl/div_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequential DIV/DIVU controller: restoring division sharing one fa32 add/sub.
// Optional macro DIV_ZERO_DIVIDEND_EARLY_EN: a zero dividend skips straight from PREP_A to DONE.

module fa32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   input  logic        sub,
   output logic [31:0] sum,
   output logic        cout
);
   always_comb begin : ripple
      logic c;
      logic bi;
      c   = cin ^ sub;
      bi  = 1'b0;
      sum = '0;
      for (int i = 0; i < 32; i++) begin
         bi     = b[i] ^ sub;
         sum[i] = a[i] ^ bi ^ c;
         c      = (a[i] & bi) | (c & (a[i] ^ bi));
      end
      cout = c;
   end
endmodule

module div_seq_ctrl #(
   parameter int DATA_W    = 32,   // fixed by the fa32 width
   parameter bit DONE_HOLD = 1'b0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   input  logic              cancel_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] quotient_o,
   output logic [DATA_W-1:0] remainder_o
);
   typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, CALC, FIX_Q, FIX_R, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] q_r, r_r, d_r;
   logic        sgn_r, qneg_r, rneg_r;
   logic [4:0]  cnt_r;
   logic [31:0] fa_a, fa_b, fa_sum, cand;
   logic        fa_cout, success, accept, load_out;
   logic [31:0] out_q_nx, out_r_nx;

   fa32 u_fa (
      .a    (fa_a),
      .b    (fa_b),
      .cin  (1'b0),
      .sub  (1'b1),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign busy_o  = (state_q != IDLE) && (state_q != DONE);
   assign done_o  = (state_q == DONE);
   assign accept  = !busy_o && start_i && !cancel_i;
   assign cand    = {r_r[30:0], q_r[31]};
   // R[31] set means the shifted candidate exceeds 32 bits, so it always beats D.
   assign success = r_r[31] | fa_cout;

   always_comb begin
      fa_a = '0;
      fa_b = q_r;
      case (state_q)
         PREP_B:  fa_b = d_r;
         CALC: begin
            fa_a = cand;
            fa_b = d_r;
         end
         FIX_R:   fa_b = r_r;
         default: fa_b = q_r;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      load_out = 1'b0;
      out_q_nx = q_r;
      out_r_nx = rneg_r ? fa_sum : r_r;
      case (state_q)
         IDLE:   if (accept) state_d = PREP_A;
         PREP_A: begin
            state_d = PREP_B;
`ifdef DIV_ZERO_DIVIDEND_EARLY_EN
            if (q_r == '0) begin
               state_d  = DONE;
               load_out = 1'b1;
               out_q_nx = '0;
               out_r_nx = '0;
            end
`endif
         end
         PREP_B: state_d = CALC;
         CALC:   if (cnt_r == 5'd31) state_d = FIX_Q;
         FIX_Q:  state_d = FIX_R;
         FIX_R: begin
            state_d  = DONE;
            load_out = 1'b1;
         end
         DONE: begin
            if (accept)          state_d = PREP_A;
            else if (cancel_i)   state_d = IDLE;
            else if (!DONE_HOLD) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (busy_o && cancel_i) begin
         state_d  = IDLE;
         load_out = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         sgn_r       <= 1'b0;
         qneg_r      <= 1'b0;
         rneg_r      <= 1'b0;
         cnt_r       <= '0;
         quotient_o  <= '0;
         remainder_o <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            sgn_r  <= signed_i;
            qneg_r <= signed_i & (dividend_i[31] ^ divisor_i[31]);
            rneg_r <= signed_i & dividend_i[31];
            cnt_r  <= '0;
         end else if (state_q == CALC) begin
            cnt_r <= cnt_r + 5'd1;
         end
         if (load_out) begin
            quotient_o  <= out_q_nx;
            remainder_o <= out_r_nx;
         end
      end
   end

   // Datapath registers carry no reset; every operation reloads them on accept.
   always_ff @(posedge clk) begin
      if (accept) begin
         q_r <= dividend_i;
         d_r <= divisor_i;
         r_r <= '0;
      end else begin
         case (state_q)
            PREP_A: if (sgn_r & q_r[31]) q_r <= fa_sum;
            PREP_B: if (sgn_r & d_r[31]) d_r <= fa_sum;
            CALC: begin
               r_r <= success ? fa_sum : cand;
               q_r <= {q_r[30:0], success};
            end
            FIX_Q:  if (qneg_r) q_r <= fa_sum;
            FIX_R:  if (rneg_r) r_r <= fa_sum;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: pulse-done and held-done instances share one stimulus.

module tb_div_seq_ctrl;
   logic        clk = 1'b0;
   logic        resetn, start_i, signed_i, cancel_i;
   logic [31:0] dividend_i, divisor_i;
   logic        busy_o, done_o, busy_h, done_h;
   logic [31:0] quotient_o, remainder_o, quot_h, rem_h;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          lat, bcnt, seen;

   always #5 clk = ~clk;

   div_seq_ctrl #(.DATA_W(32), .DONE_HOLD(1'b0)) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .start_i     (start_i),
      .signed_i    (signed_i),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .cancel_i    (cancel_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .quotient_o  (quotient_o),
      .remainder_o (remainder_o)
   );

   div_seq_ctrl #(.DATA_W(32), .DONE_HOLD(1'b1)) u_dut_h (
      .clk         (clk),
      .resetn      (resetn),
      .start_i     (start_i),
      .signed_i    (signed_i),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .cancel_i    (cancel_i),
      .busy_o      (busy_h),
      .done_o      (done_h),
      .quotient_o  (quot_h),
      .remainder_o (rem_h)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      signed_i   = sgn;
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      tick();
      start_i    = 1'b0;
   endtask

   task automatic wait_done(output int l, output int bc);
      l  = 0;
      bc = 0;
      while (!done_o && l < 100) begin
         if (busy_o) bc++;
         tick();
         l++;
      end
      chk("done_seen", {31'b0, done_o}, 32'd1);
   endtask

   task automatic run(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eq, input logic [31:0] er);
      launch(sgn, a, b);
      wait_done(lat, bcnt);
      chk({tag, "_lat"},  lat,  32'd36);
      chk({tag, "_busy"}, bcnt, 32'd36);
      chk({tag, "_q"},    quotient_o,  eq);
      chk({tag, "_r"},    remainder_o, er);
   endtask

   initial begin
      resetn = 1'b0; start_i = 1'b0; cancel_i = 1'b0; signed_i = 1'b0;
      dividend_i = '0; divisor_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_done", {31'b0, done_o}, 32'd0);
      chk("rst_q", quotient_o, 32'd0);
      chk("rst_r", remainder_o, 32'd0);
      chk("rst_done_h", {31'b0, done_h}, 32'd0);
      @(negedge clk) resetn = 1'b1;
      tick();

      run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002);
      tick();
      chk("pulse_done", {31'b0, done_o}, 32'd0);
      chk("hold_done",  {31'b0, done_h}, 32'd1);
      chk("hold_q", quot_h, 32'h0000000E);

      run("div_m7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
      run("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
      run("divu_5_0",   1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'h00000005);

      launch(1'b0, 32'd1000, 32'd3);
      repeat (9) tick();
      cancel_i = 1'b1;
      tick();
      cancel_i = 1'b0;
      chk("cancel_busy", {31'b0, busy_o}, 32'd0);
      chk("cancel_done", {31'b0, done_o}, 32'd0);
      chk("cancel_q", quotient_o,  32'hFFFFFFFF);
      chk("cancel_r", remainder_o, 32'h00000005);
      chk("cancel_done_h", {31'b0, done_h}, 32'd0);
      seen = 0;
      repeat (40) begin
         if (done_o) seen = 1;
         tick();
      end
      chk("cancel_nodone", seen, 32'd0);
      run("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

      launch(1'b0, 32'd20, 32'd6);
      repeat (4) tick();
      dividend_i = 32'd100;
      divisor_i  = 32'd7;
      start_i    = 1'b1;
      tick();
      start_i    = 1'b0;
      chk("ign_busy", {31'b0, busy_o}, 32'd1);
      wait_done(lat, bcnt);
      chk("ign_lat", lat + 5, 32'd36);
      chk("ign_q", quotient_o,  32'd3);
      chk("ign_r", remainder_o, 32'd2);

      run("b2b_50_7", 1'b0, 32'd50, 32'd7, 32'd7, 32'd1);
      tick();
      tick();
      chk("hold_stay",  {31'b0, done_h}, 32'd1);
      chk("pulse_idle", {31'b0, done_o}, 32'd0);
      launch(1'b0, 32'd9, 32'd3);
      chk("hold_clr",  {31'b0, done_h}, 32'd0);
      chk("hold_busy", {31'b0, busy_h}, 32'd1);
      wait_done(lat, bcnt);
      chk("hold_run_lat", lat, 32'd36);
      chk("hold_run_q", quot_h, 32'd3);

      launch(1'b0, 32'd1000, 32'd3);
      repeat (19) tick();
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
      chk("mid_rst_done", {31'b0, done_o}, 32'd0);
      chk("mid_rst_q", quotient_o,  32'd0);
      chk("mid_rst_r", remainder_o, 32'd0);
      chk("mid_rst_q_h", quot_h, 32'd0);
      @(negedge clk) resetn = 1'b1;
      tick();
      run("post_rst_1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
